// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN (adds the CHECK state).
package imem_loader_pkg;

  localparam int unsigned IMEM_DEPTH  = 1024;
  localparam int unsigned IMEM_ADDR_W = 10;
  localparam int unsigned LEN_W       = 16;
  localparam int unsigned WORD_W      = 32;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLenLo = 3'd1,
    StLenHi = 3'd2,
    StData  = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    StCheck = 3'd4,
`endif
    StDone  = 3'd5,
    StErr   = 3'd6
  } state_e;

  // A word count is usable only if it is non-zero and fits the memory.
  function automatic logic len_ok(input logic [LEN_W-1:0] len, input int unsigned depth);
    return (len != '0) && (32'(len) <= depth);
  endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted bytes into little-endian 32-bit words; the first byte of a
// word lands in bits [7:0]. o_word_valid pulses for one cycle after the 4th byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic [1:0]        o_cnt,
  output logic              o_word_valid,
  output logic [WORD_W-1:0] o_word
);

  logic [1:0]        r_cnt;
  logic [23:0]       r_shift;
  logic              r_word_valid;
  logic [WORD_W-1:0] r_word;

  // Byte counter, partial-word shifter and registered word output.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt        <= 2'd0;
      r_shift      <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= '0;
    end else begin
      r_word_valid <= 1'b0;
      if (i_clear) begin
        r_cnt   <= 2'd0;
        r_shift <= 24'd0;
      end else if (i_accept) begin
        r_cnt   <= r_cnt + 2'd1;
        r_shift <= {i_byte, r_shift[23:8]};
        if (r_cnt == 2'd3) begin
          r_word_valid <= 1'b1;
          r_word       <= {i_byte, r_shift};
        end
      end
    end
  end

  assign o_cnt        = r_cnt;
  assign o_word_valid = r_word_valid;
  assign o_word       = r_word;

endmodule

// File: rtl/imem_loader.sv
// Boot loader: receives LEN_LO, LEN_HI, then 4*N bytes, and writes N words to
// instruction memory from address 0 while stalling the core.
// Optional macro IMEM_LOADER_CHECKSUM_EN: a trailing mod-256 sum byte over the
// data bytes is checked in CHECK; mismatch ends in ERR.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = IMEM_DEPTH,
  parameter int unsigned ADDR_W = IMEM_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_byte_valid,
  input  logic [7:0]        i_byte_data,
  output logic              o_byte_ready,
  output logic              o_wr_en,
  output logic [ADDR_W-1:0] o_wr_addr,
  output logic [31:0]       o_wr_data,
  output logic              o_cpu_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_error
);

  state_e            r_state, w_state_next;
  logic [7:0]        r_len_lo;
  logic [LEN_W-1:0]  r_len;
  logic [ADDR_W:0]   r_word_cnt;
  logic              r_all_bytes;

  logic              w_in_load;
  logic              w_accept;
  logic              w_start;
  logic              w_data_acc;
  logic              w_last_byte;
  logic [LEN_W-1:0]  w_len;
  logic [1:0]        w_pack_cnt;
  logic              w_word_valid;
  logic [WORD_W-1:0] w_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_sum;
  assign w_in_load = (r_state == StLenLo) || (r_state == StLenHi) || (r_state == StData) ||
                     (r_state == StCheck);
`else
  assign w_in_load = (r_state == StLenLo) || (r_state == StLenHi) || (r_state == StData);
`endif

  assign w_accept = i_byte_valid & o_byte_ready;
  assign w_start  = i_start & ((r_state == StIdle) || (r_state == StDone) || (r_state == StErr));
  assign w_len    = {i_byte_data, r_len_lo};
  // Once every data byte is in, a byte seen during the final write strobe is not data.
  assign w_data_acc  = w_accept & (r_state == StData) & ~r_all_bytes;
  assign w_last_byte = w_data_acc & (w_pack_cnt == 2'd3) &
                       (LEN_W'(r_word_cnt) == (r_len - LEN_W'(1)));

  imem_loader_byte_packer u_byte_packer (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_clear      (w_start),
    .i_accept     (w_data_acc),
    .i_byte       (i_byte_data),
    .o_cnt        (w_pack_cnt),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // Next-state decode for the load sequence.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone, StErr: begin
        if (i_start) w_state_next = StLenLo;
      end
      StLenLo: begin
        if (w_accept) w_state_next = StLenHi;
      end
      StLenHi: begin
        if (w_accept) w_state_next = len_ok(w_len, DEPTH) ? StData : StErr;
      end
      StData: begin
        if (w_word_valid && r_all_bytes) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          // A check byte arriving alongside the last strobe is judged right away.
          if (w_accept) w_state_next = (i_byte_data == r_sum) ? StDone : StErr;
          else          w_state_next = StCheck;
`else
          w_state_next = StDone;
`endif
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (w_accept) w_state_next = (i_byte_data == r_sum) ? StDone : StErr;
      end
`endif
      default: w_state_next = StIdle;
    endcase
  end

  // State, header length, word address counter and end-of-data flag.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= StIdle;
      r_len_lo    <= 8'd0;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_all_bytes <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == StLenLo && w_accept) r_len_lo <= i_byte_data;
      if (r_state == StLenHi && w_accept) r_len <= w_len;
      if (w_start) begin
        r_word_cnt  <= '0;
        r_all_bytes <= 1'b0;
      end else begin
        if (w_word_valid) r_word_cnt <= r_word_cnt + 1'b1;
        if (w_last_byte) r_all_bytes <= 1'b1;
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running mod-256 sum of data bytes only.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sum <= 8'd0;
    end else if (w_start) begin
      r_sum <= 8'd0;
    end else if (w_data_acc) begin
      r_sum <= r_sum + i_byte_data;
    end
  end
`endif

  assign o_byte_ready = w_in_load;
  assign o_busy       = w_in_load;
  assign o_cpu_stall  = w_in_load;
  assign o_done       = (r_state == StDone);
  assign o_error      = (r_state == StErr);
  assign o_wr_en      = w_word_valid;
  assign o_wr_addr    = r_word_cnt[ADDR_W-1:0];
  assign o_wr_data    = w_word;

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time controller for the instruction memory. It receives a program image as a byte stream over a valid/ready handshake and packs it into little-endian 32-bit words. Each word is written to the instruction memory's write port at consecutive word addresses from 0. The core is held in stall while a load is in progress. The block sits between the host byte source (UART receiver) and the instruction memory, and drives the core's fetch-stall input.

## Interface
Parameters:
- DEPTH, 1024, instruction memory depth in words (4 KB)
- ADDR_W, 10, word-address width, equal to clog2(DEPTH)

Ports:
- clk  in  1  single clock
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  pulse; begins a load
- byte_valid  in  1  byte_data is valid this cycle
- byte_data  in  8  stream byte
- byte_ready  out  1  block accepts a byte this cycle
- wr_en  out  1  one-cycle instruction-memory write strobe
- wr_addr  out  ADDR_W  word address (byte address >> 2)
- wr_data  out  32  word to write
- cpu_stall  out  1  holds the core's PC/fetch
- busy  out  1  load in progress
- done  out  1  sticky; last load completed successfully
- error  out  1  sticky; last load aborted

## Operation
- Stream format: LEN_LO, LEN_HI (word count N, little-endian, 16-bit), then 4·N data bytes (byte 0 = instr[7:0]). With IMEM_LOADER_CHECKSUM_EN, one trailing checksum byte follows.
- A byte is accepted when byte_valid & byte_ready.
- FSM states: IDLE, LEN_LO, LEN_HI, DATA, CHECK, DONE, ERR. CHECK exists only with the macro.
- IDLE/DONE/ERR + start -> LEN_LO. This clears done, error, the byte counter and the address counter.
- start in any other state is ignored.
- LEN_LO -> LEN_HI on accept.
- LEN_HI -> DATA on accept when 1 ≤ N ≤ DEPTH. Otherwise -> ERR, with no writes.
- DATA: packs bytes with a 2-bit byte counter. On acceptance of the 4th byte, the registered outputs the next cycle are: wr_en=1, wr_addr=word counter, wr_data=packed word. The word counter then increments.
- After word N-1 is written: -> DONE, or -> CHECK with the macro.
- byte_ready = 1 in LEN_LO, LEN_HI, DATA, CHECK; 0 elsewhere.
- cpu_stall = busy = 1 in LEN_LO..CHECK.
- DONE/ERR: stall released, done or error set respectively. Error leaves partially written memory as is.
- Arithmetic:
  - word counter is ADDR_W+1 bits and never wraps past DEPTH-1, because of the N check.
  - N = DEPTH exactly is legal.

## Timing
- Reset values: byte_ready=0, wr_en=0, wr_addr=0, wr_data=0, cpu_stall=0, busy=0, done=0, error=0, state IDLE.
- Latency: wr_en asserts exactly 1 cycle after the 4th byte of a word is accepted and lasts 1 cycle.
- Back-to-back bytes (byte_valid held high) sustain 1 word per 4 cycles with no bubbles. byte_ready never deasserts within DATA.
- Gaps in byte_valid stall the packer indefinitely. There is no timeout.
- State transitions:
  - DONE/ERR is entered the cycle after the last write strobe, or the cycle after the check byte is accepted.
  - cpu_stall falls in that same cycle.
- start coincident with byte_valid in IDLE: the byte is not accepted, because byte_ready is 0 in IDLE.
- Reset mid-load: all outputs return to reset values on the next edge. The partial word is discarded and no wr_en is issued for it.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - An 8-bit running sum (mod 256) covers all data bytes, not the header.
  - The trailing byte is accepted in CHECK. Equal -> DONE, unequal -> ERR.
  - All data words have already been written when CHECK is evaluated.
- Undefined: no CHECK state, no checksum byte consumed, and DATA -> DONE directly.

## Structure
- Package imem_loader_pkg holds:
  - state enum
  - IMEM_DEPTH = 1024
  - IMEM_ADDR_W = 10
  - LEN_W = 16
- Sub-module byte_packer: 2-bit counter plus 32-bit shift/assemble register. Its outputs are word_valid and word.
- The FSM, address counter and checksum live in imem_loader.

## Test plan
- Load N=2: bytes 02 00 13 05 10 00 93 05 20 00 -> wr_en at addr 0 data 0x00100513, then addr 1 data 0x00200593; done=1, cpu_stall 1->0.
- N=0 header (00 00) -> ERR, error=1, no wr_en.
- N=1025 header (01 04) -> ERR, error=1, no wr_en.
- byte_valid toggled 1/0 every cycle during N=3 -> correct words at addrs 0..2. Each write lands one cycle after its 4th accepted byte.
- rst_n low after 6 data bytes -> all outputs 0 next cycle. Only addr 0 was written. A following start plus a full N=1 stream completes normally.
- Checksum:
  - With IMEM_LOADER_CHECKSUM_EN, N=1 data 13 05 10 00 and checksum 0x28 -> done=1.
  - Checksum 0x29 -> error=1, and addr 0 is still written.
